// File: rtl/si4463_pkg.sv
// Shared definitions for the Si4463 SPI responder: opcodes, status bit
// positions and the transaction state encoding.
package si4463_pkg;

    localparam logic [7:0] OP_READ_CMD_BUFF  = 8'h44;
    localparam logic [7:0] OP_WRITE_TX_FIFO  = 8'h66;
    localparam logic [7:0] OP_READ_RX_FIFO   = 8'h77;
    localparam logic [7:0] OP_FIFO_INFO      = 8'h15;
    localparam logic [7:0] OP_START_TX       = 8'h31;
    localparam logic [7:0] OP_GET_INT_STATUS = 8'h20;

    localparam int PH_PACKET_SENT_BIT = 5;
    localparam int PH_PACKET_RX_BIT   = 4;
    localparam int CHIP_FIFO_ERR_BIT  = 5;

    localparam int RESP_BYTES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD_IN,
        ST_RESP_OUT,
        ST_FIFO_OUT,
        ST_BUSY
    } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with synchronous push/pop/clear and a combinational head
// so the next read byte can be presented before the pop is committed.
module byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [7:0]               i_din,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok, w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // NOTE: storage is not reset; pointers and count decide what is valid, so this maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/si4463_spi_responder.sv
// SPI-slave stand-in for the Si4463 command interface: CTS/response polling,
// TX-to-RX FIFO loopback, a TX timer raising packet interrupts on nIRQ.
module si4463_spi_responder
    import si4463_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int BUSY_CYCLES = 200,
    parameter int TX_CYCLES   = 5000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sdn,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic       irq_n,
    output logic [7:0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BUSY_CYCLES + 1);
    localparam int TW = $clog2(TX_CYCLES + 1);

    logic [2:0] r_sclk_sync, r_ss_sync;
    logic [1:0] r_mosi_sync, r_sdn_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sdn_sync  <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_ss_sync   <= {r_ss_sync[1:0], ss_n};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_sdn_sync  <= {r_sdn_sync[0], sdn};
        end
    end

    // Synchronized sdn joins the pad reset; its release is already clk-aligned.
    logic w_rst_n, w_ss, w_mosi, w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
    assign w_rst_n     = reset_n & ~r_sdn_sync[1];
    assign w_ss        = r_ss_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_ss_fall   = ~r_ss_sync[1] &  r_ss_sync[2];
    assign w_ss_rise   =  r_ss_sync[1] & ~r_ss_sync[2];
    assign w_sclk_rise = ~w_ss &  r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~w_ss & ~r_sclk_sync[1] &  r_sclk_sync[2];

    state_t        r_state, w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_rx_shift, r_tx_shift, r_tx_next, r_byte_idx, r_opcode;
    logic          r_cts_ok, r_ovf, r_unf, r_irq_n;
    logic [7:0]    r_resp [RESP_BYTES];
    logic [7:0]    r_ph_pend, w_ph_pend_nxt, w_chip_pend, w_int_pend, w_tx_next, w_rx_byte;
    logic [3:0]    w_resp_idx;
    logic [BW-1:0] r_busy_cnt;
    logic [TW-1:0] r_tx_cnt;
    logic [7:0]    w_fifo_head;
    logic [AW:0]   w_fifo_count;
    logic          w_full, w_empty, w_push, w_pop, w_pop_req, w_flush, w_wr_byte;
    logic          w_active, w_byte_done, w_cmd_done, w_busy, w_generic_end;
    logic          w_start_tx, w_int_clr, w_tx_expire;

    assign w_active      = (r_state == ST_CMD) || (r_state == ST_PAYLOAD_IN) ||
                           (r_state == ST_RESP_OUT) || (r_state == ST_FIFO_OUT);
    assign w_byte_done   = w_active && w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_rx_byte     = {r_rx_shift[6:0], w_mosi};
    assign w_cmd_done    = w_byte_done && (r_state == ST_CMD);
    assign w_busy        = (r_busy_cnt != '0);
    assign w_generic_end = w_ss_rise && (r_state == ST_PAYLOAD_IN) && (r_opcode != OP_WRITE_TX_FIFO);
    assign w_start_tx    = w_generic_end && (r_opcode == OP_START_TX);
    assign w_wr_byte     = w_byte_done && (r_state == ST_PAYLOAD_IN) && (r_opcode == OP_WRITE_TX_FIFO);
    assign w_push        = w_wr_byte && !w_full;
    // A read pop commits on the first SCLK rise of its byte, so the byte after the last one clocked is never consumed.
    assign w_pop_req     = (r_state == ST_FIFO_OUT) && w_sclk_rise && (r_bit_cnt == 3'd0);
    assign w_pop         = w_pop_req && !w_empty;
    assign w_flush       = w_byte_done && (r_state == ST_PAYLOAD_IN) && (r_opcode == OP_FIFO_INFO) &&
                           (r_byte_idx == 8'd1) && w_rx_byte[0];
    assign w_int_clr     = w_cmd_done && (w_rx_byte == OP_GET_INT_STATUS);
    assign w_tx_expire   = (r_tx_cnt == TW'(1));
    assign w_chip_pend   = 8'(r_ovf | r_unf) << CHIP_FIFO_ERR_BIT;
    assign w_int_pend    = {5'b0, |w_chip_pend, 1'b0, |r_ph_pend};

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (w_rst_n),
        .i_clr   (w_flush),
        .i_push  (w_push),
        .i_din   (w_rx_byte),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // NOTE: defaults first so every path assigns and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (w_ss_fall) begin
            w_state_nxt = ST_CMD;
        end else if (w_ss_rise && w_active) begin
            w_state_nxt = (w_generic_end || w_busy) ? ST_BUSY : ST_IDLE;
        end else begin
            case (r_state)
                ST_CMD: if (w_cmd_done) begin
                    if (w_rx_byte == OP_READ_CMD_BUFF)     w_state_nxt = ST_RESP_OUT;
                    else if (w_rx_byte == OP_READ_RX_FIFO) w_state_nxt = ST_FIFO_OUT;
                    else                                   w_state_nxt = ST_PAYLOAD_IN;
                end
                ST_BUSY: if (!w_busy) w_state_nxt = ST_IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_tx_next  = 8'h00;
        w_resp_idx = 4'(r_byte_idx - 8'd1);
        case (r_state)
            ST_CMD: begin
                if (w_rx_byte == OP_READ_CMD_BUFF)                 w_tx_next = w_busy ? 8'h00 : 8'hFF;
                else if (w_rx_byte == OP_READ_RX_FIFO && !w_empty) w_tx_next = w_fifo_head;
            end
            ST_RESP_OUT: if (r_cts_ok && r_byte_idx <= 8'(RESP_BYTES)) w_tx_next = r_resp[w_resp_idx];
            ST_FIFO_OUT: if (!w_empty) w_tx_next = w_fifo_head;
            default: ;
        endcase
    end

    always_comb begin
        w_ph_pend_nxt = r_ph_pend;
        if (w_int_clr) w_ph_pend_nxt = '0;
        if (w_tx_expire) begin
            w_ph_pend_nxt[PH_PACKET_SENT_BIT] = 1'b1;
            w_ph_pend_nxt[PH_PACKET_RX_BIT]   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_tx_next  <= '0;
            r_byte_idx <= '0;
            r_opcode   <= '0;
            r_cts_ok   <= 1'b0;
        end else if (w_ss_fall || w_ss_rise) begin
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_tx_shift <= '0;
            r_tx_next  <= '0;
        end else if (w_active) begin
            if (w_sclk_rise) begin
                r_rx_shift <= w_rx_byte;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_tx_next <= w_tx_next;
                    if (r_byte_idx != 8'hFF) r_byte_idx <= r_byte_idx + 8'd1;
                end
            end
            if (w_sclk_fall) r_tx_shift <= (r_bit_cnt == 3'd0) ? r_tx_next : {r_tx_shift[6:0], 1'b0};
            if (w_cmd_done) begin
                r_opcode <= w_rx_byte;
                r_cts_ok <= !w_busy;
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < RESP_BYTES; i++) r_resp[i] <= 8'h00;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_ph_pend  <= '0;
            r_irq_n    <= 1'b1;
            r_busy_cnt <= '0;
            r_tx_cnt   <= '0;
        end else begin
            r_ph_pend <= w_ph_pend_nxt;
            r_irq_n   <= ~|w_ph_pend_nxt;
            if (w_int_clr) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            if (w_wr_byte && w_full)  r_ovf <= 1'b1;
            if (w_pop_req && w_empty) r_unf <= 1'b1;
            if (w_generic_end) r_busy_cnt <= BW'(BUSY_CYCLES);
            else if (w_busy)   r_busy_cnt <= r_busy_cnt - 1'b1;
            if (w_start_tx)             r_tx_cnt <= TW'(TX_CYCLES);
            else if (r_tx_cnt != '0)    r_tx_cnt <= r_tx_cnt - 1'b1;
            if (w_cmd_done && w_rx_byte != OP_READ_CMD_BUFF &&
                w_rx_byte != OP_WRITE_TX_FIFO && w_rx_byte != OP_READ_RX_FIFO) begin
                for (int i = 0; i < RESP_BYTES; i++) r_resp[i] <= 8'h00;
                if (w_rx_byte == OP_FIFO_INFO) begin
                    r_resp[0] <= 8'(w_fifo_count);
                    r_resp[1] <= 8'(FIFO_DEPTH) - 8'(w_fifo_count);
                end else if (w_rx_byte == OP_GET_INT_STATUS) begin
                    r_resp[0] <= w_int_pend;
                    r_resp[1] <= w_int_pend;
                    r_resp[2] <= r_ph_pend;
                    r_resp[3] <= r_ph_pend;
                    r_resp[4] <= w_chip_pend;
                end
            end
        end
    end

    assign miso       = r_tx_shift[7];
    assign irq_n      = r_irq_n;
    assign fifo_count = 8'(w_fifo_count);

endmodule
